// File: rtl/alu_iter_if.sv
// Handshake bundle for alu_iter: operation request in, registered result out.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flag;
  logic [3:0]       cmp;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  flag, cmp, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output flag, cmp, illegal
  );
endinterface

// File: rtl/alu_iter.sv
// Handshaked ALU; shifts iterate one bit per cycle unless
// ALU_ITER_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_iter #(
  parameter int WIDTH      = 32,
  parameter bit CMP_SIGNED = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_iter_if.slave io
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;

`ifdef ALU_ITER_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flag_q;
  logic [3:0]       cmp_q;
  logic             illegal_q;
  logic             valid_q;
  logic             ready;
  logic             accept;

  logic             is_add, is_sub, is_and, is_or;
  logic             is_xor, is_sra, is_sll, is_srl;
  logic             is_shift;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_n;
  logic             ov, co, lt, eq;
  logic [3:0]       flag_n;
  logic [3:0]       cmp_n;
  logic             illegal_n;

  assign is_add   = io.op == OP_ADD;
  assign is_sub   = io.op == OP_SUB;
  assign is_and   = io.op == OP_AND;
  assign is_or    = io.op == OP_OR;
  assign is_xor   = io.op == OP_XOR;
  assign is_sra   = io.op == OP_SRA;
  assign is_sll   = io.op == OP_SLL;
  assign is_srl   = io.op == OP_SRL;
  assign is_shift = is_sra | is_sll | is_srl;
  assign amt      = io.b[SW-1:0];

  // SUB reuses the adder as a + ~b + 1, so one overflow rule covers both
  assign bx  = is_sub ? ~io.b : io.b;
  assign sum = {1'b0, io.a} + {1'b0, bx}
             + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    res_n     = '0;
    ov        = 1'b0;
    co        = 1'b0;
    illegal_n = 1'b0;
    unique case (1'b1)
      is_add, is_sub: begin
        res_n = sum[WIDTH-1:0];
        co    = sum[WIDTH];
        ov    = (io.a[WIDTH-1] == bx[WIDTH-1])
              && (res_n[WIDTH-1] != io.a[WIDTH-1]);
      end
      is_and: res_n = io.a & io.b;
      is_or:  res_n = io.a | io.b;
      is_xor: res_n = io.a ^ io.b;
`ifdef ALU_ITER_BARREL_SHIFT_EN
      is_sra: res_n = WIDTH'($signed(io.a) >>> amt);
      is_sll: res_n = io.a << amt;
      is_srl: res_n = io.a >> amt;
`else
      is_shift: res_n = io.a;
`endif
      default: illegal_n = 1'b1;
    endcase
  end

  assign flag_n = {res_n[WIDTH-1], res_n == '0, ov, co};

  assign eq = io.a == io.b;
  assign lt = CMP_SIGNED ? ($signed(io.a) < $signed(io.b))
                         : (io.a < io.b);
  assign cmp_n = {!lt, lt, !eq, eq};

`ifdef ALU_ITER_BARREL_SHIFT_EN
  assign ready = (state == IDLE) || io.out_ready;
`else
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_n;
  logic [SW-1:0]    cnt;
  logic [3:0]       sop;

  assign ready = (state == IDLE)
              || (state == DONE && io.out_ready);

  always_comb begin
    work_n = {work[WIDTH-1], work[WIDTH-1:1]};
    unique case (1'b1)
      sop == OP_SLL: work_n = {work[WIDTH-2:0], 1'b0};
      sop == OP_SRL: work_n = {1'b0, work[WIDTH-1:1]};
      default:       work_n = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end
`endif

  assign accept = io.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result_q  <= '0;
      flag_q    <= '0;
      cmp_q     <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
`ifndef ALU_ITER_BARREL_SHIFT_EN
      work      <= '0;
      cnt       <= '0;
      sop       <= '0;
`endif
    end else begin
`ifndef ALU_ITER_BARREL_SHIFT_EN
      if (state == SHIFT) begin
        work <= work_n;
        cnt  <= cnt - SW'(1);
        if (cnt == SW'(1)) begin
          state    <= DONE;
          valid_q  <= 1'b1;
          result_q <= work_n;
          flag_q   <= {work_n[WIDTH-1],
                       work_n == '0, 2'b00};
        end
      end else
`endif
      if (accept) begin
        cmp_q     <= cmp_n;
        illegal_q <= illegal_n;
`ifndef ALU_ITER_BARREL_SHIFT_EN
        if (is_shift && amt != '0) begin
          state   <= SHIFT;
          valid_q <= 1'b0;
          work    <= io.a;
          cnt     <= amt;
          sop     <= io.op;
        end else
`endif
        begin
          state    <= DONE;
          valid_q  <= 1'b1;
          result_q <= res_n;
          flag_q   <= flag_n;
        end
      end else if (io.out_ready) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready  = ready;
  assign io.out_valid = valid_q;
  assign io.result    = result_q;
  assign io.flag      = flag_q;
  assign io.cmp       = cmp_q;
  assign io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expected results queued at accept,
// compared when the DUT hands a result to the consumer.
module tb_alu_iter;
  localparam int W = 32;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  c;
    logic        il;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(W)) io ();

  alu_iter #(
    .WIDTH(W),
    .CMP_SIGNED(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  int   checks = 0;
  int   fails = 0;
  exp_t q[$];
  bit   watch_ov = 1'b0;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    logic ov, co, lt;
    int k;
    k = int'(b[4:0]);
    ov = 1'b0;
    co = 1'b0;
    e.il = 1'b0;
    e.r = '0;
    case (op)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      4'd2: begin
        e.r = a - b;
        co = (a >= b);
        ov = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      4'd3: e.r = a & b;
      4'd4: e.r = a | b;
      4'd5: e.r = a ^ b;
      4'd6: e.r = $signed(a) >>> k;
      4'd7: e.r = a << k;
      4'd8: e.r = a >> k;
      default: begin
        e.r = '0;
        e.il = 1'b1;
      end
    endcase
    e.f = {e.r[31], e.r == 32'd0, ov, co};
    lt = $signed(a) < $signed(b);
    e.c = {!lt, lt, a != b, a == b};
    return e;
  endfunction

  // Consumer side: every transfer pops and checks one expected entry
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty result=%h with no expected entry",
                 io.result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (io.result !== e.r) begin
          fails++;
          $display("FAIL sb_result got %h want %h", io.result, e.r);
        end
        checks++;
        if (io.flag !== e.f) begin
          fails++;
          $display("FAIL sb_flag got %b want %b", io.flag, e.f);
        end
        checks++;
        if (io.cmp !== e.c) begin
          fails++;
          $display("FAIL sb_cmp got %b want %b", io.cmp, e.c);
        end
        checks++;
        if (io.illegal !== e.il) begin
          fails++;
          $display("FAIL sb_illegal got %b want %b",
                   io.illegal, e.il);
        end
      end
    end
    if (watch_ov) begin
      checks++;
      if (io.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_out_valid got %b want 1", io.out_valid);
      end
    end
  end

  task automatic send(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    io.in_valid = 1'b1;
    io.op = op;
    io.a = a;
    io.b = b;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (io.in_ready === 1'b1) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL handshake_timeout op=%0d in_ready got %b want 1",
               op, io.in_ready);
    end else begin
      q.push_back(model(op, a, b));
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    io.in_valid = 1'b0;
    io.op = '0;
    io.a = '0;
    io.b = '0;
    io.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0",
               io.in_ready, io.out_valid);
    end
    checks++;
    if (io.result !== 32'd0 || io.flag !== 4'd0 ||
        io.cmp !== 4'd0 || io.illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_out got r=%h f=%b c=%b il=%b want zeros",
               io.result, io.flag, io.cmp, io.illegal);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_add();
    io.out_ready = 1'b1;
    send(4'd1, 32'h7FFF_FFFF, 32'd1);
    idle();
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b1 || io.result !== 32'h8000_0000) begin
      fails++;
      $display("FAIL add_ovf got vld=%b r=%h want vld=1 r=80000000",
               io.out_valid, io.result);
    end
    checks++;
    if (io.flag !== 4'b1010 || io.cmp !== 4'b1010) begin
      fails++;
      $display("FAIL add_flags got f=%b c=%b want f=1010 c=1010",
               io.flag, io.cmp);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_sub();
    io.out_ready = 1'b1;
    send(4'd2, 32'd5, 32'd5);
    idle();
    @(negedge clk);
    checks++;
    if (io.result !== 32'd0 || io.flag !== 4'b0101 ||
        io.cmp !== 4'b1001) begin
      fails++;
      $display("FAIL sub_eq got r=%h f=%b c=%b want 0 0101 1001",
               io.result, io.flag, io.cmp);
    end
    @(posedge clk);
    #2;
    send(4'd2, 32'd3, 32'd5);
    idle();
    @(negedge clk);
    checks++;
    if (io.result !== 32'hFFFF_FFFE || io.flag[0] !== 1'b0 ||
        io.cmp[2] !== 1'b1) begin
      fails++;
      $display("FAIL sub_lt got r=%h co=%b lt=%b want fffffffe 0 1",
               io.result, io.flag[0], io.cmp[2]);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_sra();
    int lat;
    int want;
    int bad_rdy;
`ifdef ALU_ITER_BARREL_SHIFT_EN
    want = 1;
`else
    want = 4;
`endif
    io.out_ready = 1'b1;
    send(4'd6, 32'h8000_0000, 32'h23);
    idle();
    lat = 0;
    bad_rdy = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (io.out_valid === 1'b1) break;
      if (io.in_ready !== 1'b0) bad_rdy++;
    end
    checks++;
    if (lat != want) begin
      fails++;
      $display("FAIL sra_latency got %0d want %0d", lat, want);
    end
    checks++;
    if (bad_rdy != 0) begin
      fails++;
      $display("FAIL sra_in_ready got %0d cycles high want 0", bad_rdy);
    end
    checks++;
    if (io.result !== 32'hF000_0000) begin
      fails++;
      $display("FAIL sra_result got %h want f0000000", io.result);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_back_to_back();
    exp_t held;
    io.out_ready = 1'b1;
    send(4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234);
    watch_ov = 1'b1;
    send(4'd3, 32'hDEAD_BEEF, 32'h00FF_FF00);
    held = model(4'd3, 32'hDEAD_BEEF, 32'h00FF_FF00);
    io.out_ready = 1'b0;
    io.op = 4'd1;
    io.a = 32'd10;
    io.b = 32'd20;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (io.in_ready !== 1'b0 || io.result !== held.r) begin
        fails++;
        $display("FAIL stall got rdy=%b r=%h want rdy=0 r=%h",
                 io.in_ready, io.result, held.r);
      end
    end
    @(posedge clk);
    #2;
    io.out_ready = 1'b1;
    send(4'd1, 32'd10, 32'd20);
    watch_ov = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b1 || io.result !== 32'd30) begin
      fails++;
      $display("FAIL b2b_after got vld=%b r=%h want 1 0000001e",
               io.out_valid, io.result);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_illegal();
    io.out_ready = 1'b1;
    send(4'b1010, 32'h12, 32'h34);
    idle();
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b1 || io.illegal !== 1'b1 ||
        io.result !== 32'd0 || io.flag !== 4'b0100) begin
      fails++;
      $display("FAIL illegal got v=%b il=%b r=%h f=%b want 1 1 0 0100",
               io.out_valid, io.illegal, io.result, io.flag);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    io.out_ready = 1'b1;
    send(4'd7, 32'd1, 32'd20);
    idle();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 ||
        io.result !== 32'd0 || io.flag !== 4'd0 ||
        io.cmp !== 4'd0 || io.illegal !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got v=%b rdy=%b r=%h want 0 1 0",
               io.out_valid, io.in_ready, io.result);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_no_valid got %0d cycles valid want 0", seen);
    end
    @(posedge clk);
    #2;
    send(4'd1, 32'd2, 32'd2);
    idle();
    @(negedge clk);
    checks++;
    if (io.out_valid !== 1'b1 || io.result !== 32'd4) begin
      fails++;
      $display("FAIL rst_then_add got v=%b r=%h want 1 00000004",
               io.out_valid, io.result);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    io.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      if (i % 5 == 0) a = 32'h8000_0000 | a;
      send(op, a, b);
    end
    idle();
  endtask

  initial begin
    int n;
    test_reset();
    test_add();
    test_sub();
    test_sra();
    test_back_to_back();
    test_illegal();
    test_reset_mid_shift();
    test_random();
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the combinational ALU op set.
- Accepts one operation per transaction on a valid/ready input.
- Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle.
- Registers result, flag vector (sign, zero, overflow, carryOut) and compare vector (ge, lt, ne, eq) until the consumer accepts them; sits between the hardwired controller's execute stage and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are powers of two, 8..64.
- CMP_SIGNED, 1, 1 = lt/ge compare operands as two's complement; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation
- op  in  4  opcode: ADD=1, SUB=2, AND=3, OR=4, XOR=5, SRA=6, SLL=7, SRL=8
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shifts only b[$clog2(WIDTH)-1:0] is used
- out_valid  out  1  result registered and stable
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- flag  out  4  {sign, zero, overflow, carryOut}, packed MSB first
- cmp  out  4  {ge, lt, ne, eq}, packed MSB first
- illegal  out  1  accepted opcode was not one of the eight legal codes

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - in_ready=1, out_valid=0, result=0, flag=0, cmp=0, illegal=0.
  - Reset mid-shift abandons the operation; no out_valid pulse follows.
- States: IDLE, SHIFT, DONE.
- Accept: a transfer occurs on a cycle where in_valid && in_ready. op, a, b are captured on that edge.
- in_ready:
  - 1 in IDLE.
  - 1 in DONE only when out_ready=1, giving back-to-back throughput.
  - 0 in SHIFT.
- From IDLE or DONE on accept:
  - Non-shift op, or shift with amount 0 → DONE; out_valid=1 next cycle. Latency is 1.
  - Shift with amount k>0 → SHIFT with counter=k; the working register is loaded with a.
- SHIFT:
  - Each cycle shifts the working register one bit: SLL inserts 0 at LSB, SRL inserts 0 at MSB, SRA replicates MSB.
  - Counter decrements; when it reaches 0 → DONE.
  - Total latency is k+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; result, flag, cmp and illegal are held stable.
  - out_ready=1 with no new accept → IDLE, out_valid=0 next cycle.
  - out_ready=1 with simultaneous accept → next op proceeds as from IDLE; out_valid stays 1 only if the new op is 1-cycle.
  - out_ready=0 → hold; input is stalled.
- Arithmetic (WIDTH+1-bit internal sum):
  - ADD: result=a+b mod 2^WIDTH; carryOut=bit WIDTH of the sum; overflow = a and b same sign, result sign differs.
  - SUB: computed as a+~b+1. carryOut=1 means no borrow (a≥b unsigned). overflow = a and b differ in sign, result sign ≠ a's sign.
  - AND/OR/XOR/shifts: overflow=0, carryOut=0.
- All ops: sign=result[WIDTH-1], zero=(result==0).
- cmp is computed from the captured a, b for every op, including shifts and illegal ops:
  - eq = a==b
  - ne = !eq
  - lt per CMP_SIGNED
  - ge = !lt
- Illegal op (0, 9..15): 1-cycle latency, result=0, flag={0,1,0,0}, illegal=1. cmp is still computed.

Optional Feature:
- Macro ALU_ITER_BARREL_SHIFT_EN.
- When defined:
  - Shifts use a single-cycle barrel shifter; every op has latency 1.
  - SHIFT state is not synthesised.
  - in_ready equals (state==IDLE) || out_ready.
- When undefined: iterative shifting as specified above.
- Result, flag and cmp values are identical in both builds; only timing differs.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF, b=1 → one cycle later: result=0x80000000, flag={1,0,1,0}, cmp={1,0,1,0}.
- SUB a=5, b=5 → result=0, flag={0,1,0,1}, cmp={1,0,0,1}. SUB a=3, b=5 → result=0xFFFFFFFE, carryOut=0, lt=1.
- SRA a=0x80000000, b=0x23 (amount 3) → out_valid 4 cycles after accept, result=0xF0000000, in_ready=0 throughout SHIFT. With macro defined: latency 1, same result.
- Back-to-back: XOR then AND, with out_ready held 1 and in_valid held 1 → one result per cycle, out_valid continuously 1. Then drop out_ready for 3 cycles → result held, in_ready=0.
- op=4'b1010 → illegal=1, result=0, flag={0,1,0,0}, 1-cycle latency.
- Assert rst_n=0 mid-SLL (amount 20) at cycle 5 → outputs clear immediately, no out_valid after release, next ADD 2+2 returns 4 at latency 1.
